// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the adder operand loader.
package adder_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } load_state_e;

    function automatic int unsigned calc_nwords(input int unsigned adder_width,
                                                input int unsigned word_width);
        return (adder_width + word_width - 1) / word_width;
    endfunction

    // A single-word operand still needs a 1-bit counter to stay legal.
    function automatic int unsigned calc_cnt_width(input int unsigned nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/operand_word_packer.sv
// Word counter plus A/B operand registers; one insert path shared by both operands via sel_b.
module operand_word_packer
    import adder_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH = 120,
    parameter int unsigned WORD_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   sel_b,
    input  logic [WORD_WIDTH-1:0]  word,
    output logic                   last_word,
    output logic [ADDER_WIDTH-1:0] a,
    output logic [ADDER_WIDTH-1:0] b
);

    localparam int unsigned NWORDS = calc_nwords(ADDER_WIDTH, WORD_WIDTH);
    localparam int unsigned CNT_W  = calc_cnt_width(NWORDS);
    localparam int unsigned PW     = NWORDS * WORD_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NWORDS - 1);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDER_WIDTH-1:0] a_q, b_q;
    logic [ADDER_WIDTH-1:0] opnd_cur, opnd_ins, word_sh, mask_sh;

    // Shift in the padded domain, then truncate: bits of the top word above ADDER_WIDTH drop out.
    always_comb begin
        opnd_cur = sel_b ? b_q : a_q;
        word_sh  = ADDER_WIDTH'(PW'(word) << (32'(cnt_q) * WORD_WIDTH));
        mask_sh  = ADDER_WIDTH'(PW'({WORD_WIDTH{1'b1}}) << (32'(cnt_q) * WORD_WIDTH));
        opnd_ins = (opnd_cur & ~mask_sh) | word_sh;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_en && !sel_b) a_q <= opnd_ins;
            if (wr_en && sel_b)  b_q <= opnd_ins;
        end
    end

    assign last_word = (cnt_q == CNT_MAX);
    assign a         = a_q;
    assign b         = b_q;

endmodule

// File: rtl/adder_operand_loader.sv
// Assembles operands A then B from a word stream and presents them as a held pair.
// Optional even-parity checking on input words is enabled by defining LOADER_PARITY_EN.
module adder_operand_loader
    import adder_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH = 120,
    parameter int unsigned WORD_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDER_WIDTH-1:0] a,
    output logic [ADDER_WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef LOADER_PARITY_EN
    ,
    input  logic                   in_par,
    output logic                   par_err
`endif
);

    if (ADDER_WIDTH < WORD_WIDTH) begin : g_width_check
        $error("adder_operand_loader: ADDER_WIDTH must not be smaller than WORD_WIDTH");
    end

    load_state_e state_q;
    logic        transfer;
    logic        last_word;

    assign transfer = in_valid && in_ready;

    operand_word_packer #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (transfer),
        .sel_b     (state_q == LOAD_B),
        .word      (in_data),
        .last_word (last_word),
        .a         (a),
        .b         (b)
    );

    // in_ready stays low in HOLD, so words presented there never reach the packer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD_A;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    in_ready <= 1'b1;
                    if (transfer && last_word) state_q <= LOAD_B;
                end
                LOAD_B: begin
                    in_ready <= 1'b1;
                    if (transfer && last_word) begin
                        state_q   <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q   <= LOAD_A;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= LOAD_A;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (out_valid && out_ready) begin
            par_err <= 1'b0;
        end else if (transfer && (^{in_data, in_par})) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_operand_loader.sv
// Scoreboard bench for adder_operand_loader: driver queues expected pairs, monitor checks them.
module tb_adder_operand_loader;

    localparam int unsigned AW = 120;
    localparam int unsigned WW = 16;
    localparam int unsigned NW = 8;
    localparam int unsigned PW = NW * WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] a, b;
    logic          out_valid;
    logic          out_ready = 1'b1;
`ifdef LOADER_PARITY_EN
    logic          in_par = 1'b0;
    logic          par_err;
`endif

    always #5 clk = ~clk;

    adder_operand_loader #(
        .ADDER_WIDTH (AW),
        .WORD_WIDTH  (WW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef LOADER_PARITY_EN
        ,
        .in_par    (in_par),
        .par_err   (par_err)
`endif
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        int unsigned   due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_accept = 0;
    int          or_mode = 0;  // 0: always ready, 1: random, 2: held low

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event within bound, required one (cycle %0d)", name, cyc);
    endtask

    // Reference: word k lands at bit 16*k; anything above bit AW-1 is lost.
    function automatic logic [AW-1:0] pack_words(input logic [WW-1:0] w [NW]);
        logic [PW-1:0] acc;
        acc = '0;
        for (int k = 0; k < int'(NW); k++) acc = acc | (PW'(w[k]) << (WW * k));
        return acc[AW-1:0];
    endfunction

    task automatic drive_word(input logic [WW-1:0] w, input int idle, input logic bad_par);
        int waited;
        waited = 0;
        repeat (idle) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            in_data  = WW'($urandom);
        end
        while (1) begin
            @(negedge clk); #1;
            in_valid = 1'b1;
            in_data  = w;
`ifdef LOADER_PARITY_EN
            in_par   = (^w) ^ bad_par;
`endif
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                timeout_fail("in_ready_wait");
                break;
            end
        end
        last_accept = cyc + 1;
    endtask

    task automatic send_packet(input logic [WW-1:0] aw [NW], input logic [WW-1:0] bw [NW],
                               input int mode, input int bad_idx, output int unsigned c0);
        exp_t e;
        c0 = 0;
        for (int i = 0; i < int'(2 * NW); i++) begin
            logic [WW-1:0] w;
            int            idle;
            w    = (i < int'(NW)) ? aw[i] : bw[i - int'(NW)];
            idle = (mode == 1) ? ((i > 0) ? 1 : 0) :
                   (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            drive_word(w, idle, i == bad_idx);
            if (i == 0) c0 = last_accept - 1;
        end
        e.a   = pack_words(aw);
        e.b   = pack_words(bw);
        e.due = last_accept;
        exp_q.push_back(e);
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || out_valid) timeout_fail("drain");
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (!out_valid) timeout_fail("out_valid_wait");
    endtask

    initial begin
        forever begin
            @(negedge clk); #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: sees outputs after the last edge alongside the inputs that edge used.
    initial begin
        logic          prev_ov;
        logic [AW-1:0] held_a, held_b;
        exp_t          e;
        prev_ov = 1'b0;
        held_a  = '0;
        held_b  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_out_valid");
                        held_a = a;
                        held_b = b;
                    end else begin
                        e = exp_q.pop_front();
                        chk("pair_a", a, e.a);
                        chk("pair_b", b, e.b);
                        chk("out_valid_latency", AW'(cyc), AW'(e.due));
                        held_a = e.a;
                        held_b = e.b;
                    end
                end else if (out_valid) begin
                    chk("hold_a", a, held_a);
                    chk("hold_b", b, held_b);
                end
                if (out_valid) chk("in_ready_in_hold", AW'(in_ready), AW'(0));
                if (prev_ov && out_ready) begin
                    chk("out_valid_after_hs", AW'(out_valid), AW'(0));
                    chk("in_ready_after_hs", AW'(in_ready), AW'(1));
`ifdef LOADER_PARITY_EN
                    chk("par_err_after_hs", AW'(par_err), AW'(0));
`endif
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WW-1:0] aw [NW];
        logic [WW-1:0] bw [NW];
        int unsigned   c0;

        repeat (2) @(negedge clk);
        chk("reset_a", a, '0);
        chk("reset_b", b, '0);
        chk("reset_out_valid", AW'(out_valid), AW'(0));
        chk("reset_in_ready", AW'(in_ready), AW'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", AW'(in_ready), AW'(1));

        // Counting words A then constant B, no stalls
        for (int k = 0; k < int'(NW); k++) begin
            aw[k] = WW'(k + 1);
            bw[k] = 16'h1111;
        end
        send_packet(aw, bw, 0, -1, c0);
        chk("plain_load_cycles", AW'(last_accept - c0), AW'(2 * NW));
        wait_drain();

        // Same words with in_valid toggling every cycle
        send_packet(aw, bw, 1, -1, c0);
        chk("toggle_load_cycles", AW'(last_accept - c0), AW'(4 * NW - 1));
        wait_drain();

        // Back-pressure in HOLD while random words are offered
        or_mode = 2;
        for (int k = 0; k < int'(NW); k++) begin
            aw[k] = WW'($urandom);
            bw[k] = WW'($urandom);
        end
        send_packet(aw, bw, 0, -1, c0);
        wait_out_valid();
        repeat (10) begin
            @(negedge clk); #1;
            in_valid = 1'b1;
            in_data  = WW'($urandom);
            chk("hold_out_valid", AW'(out_valid), AW'(1));
        end
        in_valid = 1'b0;
        or_mode  = 0;
        wait_drain();

        // Reset mid-way through operand A
        for (int k = 0; k < 4; k++) drive_word(WW'($urandom_range(1, 16'hffff)), 0, 1'b0);
        @(negedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midreset_a", a, '0);
        chk("midreset_b", b, '0);
        chk("midreset_out_valid", AW'(out_valid), AW'(0));
        chk("midreset_in_ready", AW'(in_ready), AW'(0));
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_midreset", AW'(in_ready), AW'(1));
        for (int k = 0; k < int'(NW); k++) begin
            aw[k] = 16'hffff;
            bw[k] = 16'hffff;
        end
        send_packet(aw, bw, 0, -1, c0);
        wait_drain();

        // Random words, random stalls, random consumer back-pressure
        or_mode = 1;
        repeat (6) begin
            for (int k = 0; k < int'(NW); k++) begin
                aw[k] = WW'($urandom);
                bw[k] = WW'($urandom);
            end
            send_packet(aw, bw, 2, -1, c0);
        end
        or_mode = 0;
        wait_drain();

`ifdef LOADER_PARITY_EN
        or_mode = 2;
        for (int k = 0; k < int'(NW); k++) begin
            aw[k] = WW'($urandom);
            bw[k] = WW'($urandom);
        end
        aw[0] = 16'h0003;
        send_packet(aw, bw, 0, 0, c0);
        wait_out_valid();
        chk("par_err_bad_word", AW'(par_err), AW'(1));
        or_mode = 0;
        wait_drain();
        or_mode = 2;
        send_packet(aw, bw, 0, -1, c0);
        wait_out_valid();
        chk("par_err_clean", AW'(par_err), AW'(0));
        or_mode = 0;
        wait_drain();
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
